// File: rtl/score_event_scheduler.sv
// Round-robin scheduler sharing one saturating score adder among collision sources; req edge to score is 2 clocks.
// No backpressure: pause freezes granting while edges keep queueing in saturating per-source counters (sticky overflow).
module score_event_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int PEND_W  = 3,
  parameter int SCORE_W = 16
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 clear,
  input  logic                 pause,
  input  logic [NUM_SRC-1:0]   req,
  input  logic [4*NUM_SRC-1:0] points,
  output logic [SCORE_W-1:0]   score,
  output logic                 add_valid,
  output logic [2:0]           add_src,
  output logic                 pending_any,
  output logic                 overflow
);

  logic [NUM_SRC-1:0]   req_d;
  logic [NUM_SRC-1:0]   evt;
  logic [PEND_W-1:0]    cnt [NUM_SRC];
  logic [NUM_SRC-1:0]   nz;
  logic [NUM_SRC-1:0]   sat;
  logic [2*NUM_SRC-1:0] nz2;
  logic [NUM_SRC-1:0]   rot;
  logic [2:0]           rr_ptr;
  logic [2:0]           rr_nxt;
  logic [3:0]           off;
  logic [3:0]           sum;
  logic                 grant_vld;
  logic [2:0]           grant_idx;
  logic [NUM_SRC-1:0]   grant_oh;
  logic [3:0]           pts;
  logic [SCORE_W:0]     score_sum;
  logic                 ovf_hit;

  assign evt = req & ~req_d;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      nz[i]  = |cnt[i];
      sat[i] = &cnt[i];
    end
  end

  assign pending_any = |nz;

  // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit is the winner.
  assign nz2 = {nz, nz};
  assign rot = nz2[rr_ptr +: NUM_SRC];

  always_comb begin
    grant_vld = 1'b0;
    off       = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_vld = 1'b1;
        off       = 4'(k);
      end
    end
    if (pause || clear) grant_vld = 1'b0;
    sum       = {1'b0, rr_ptr} + off;
    grant_idx = (sum >= 4'(NUM_SRC)) ? 3'(sum - 4'(NUM_SRC)) : 3'(sum);
    rr_nxt    = (grant_idx == 3'(NUM_SRC - 1)) ? 3'd0 : grant_idx + 3'd1;
  end

  always_comb begin
    grant_oh = '0;
    pts      = '0;
    ovf_hit  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_oh[i] = grant_vld && (grant_idx == 3'(i));
      if (grant_oh[i]) pts = points[4*i +: 4];
      if (evt[i] && sat[i] && !grant_oh[i]) ovf_hit = 1'b1;
    end
  end

  assign score_sum = {1'b0, score} + {{(SCORE_W-3){1'b0}}, pts};

  // An edge coinciding with a grant nets to zero, so a saturated counter loses nothing then.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (evt[i] && !grant_oh[i]) begin
          if (!sat[i]) cnt[i] <= cnt[i] + PEND_W'(1);
        end else if (!evt[i] && grant_oh[i]) begin
          cnt[i] <= cnt[i] - PEND_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      req_d     <= '0;
      rr_ptr    <= '0;
      score     <= '0;
      add_valid <= 1'b0;
      add_src   <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      req_d     <= req;
      rr_ptr    <= '0;
      score     <= '0;
      add_valid <= 1'b0;
      add_src   <= '0;
      overflow  <= 1'b0;
    end else begin
      req_d     <= req;
      add_valid <= grant_vld;
      if (ovf_hit) overflow <= 1'b1;
      if (grant_vld) begin
        rr_ptr  <= rr_nxt;
        add_src <= grant_idx;
        score   <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_score_event_scheduler.sv
// Directed bench for score_event_scheduler: per-cycle vector table plus sequences for saturation, clear and reset.
module tb_score_event_scheduler;

  logic        clk = 1'b0;
  logic        resetN;
  logic        clear;
  logic        pause;
  logic [3:0]  req;
  logic [15:0] points;
  logic [15:0] score;
  logic        add_valid;
  logic [2:0]  add_src;
  logic        pending_any;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  score_event_scheduler #(.NUM_SRC(4), .PEND_W(3), .SCORE_W(16)) dut (
    .clk(clk), .resetN(resetN), .clear(clear), .pause(pause),
    .req(req), .points(points), .score(score), .add_valid(add_valid),
    .add_src(add_src), .pending_any(pending_any), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        pau;
    logic [3:0]  rq;
    logic [15:0] pt;
    logic [15:0] e_score;
    logic        e_av;
    logic [2:0]  e_src;
    logic        e_pend;
    logic        e_ovf;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic award(input logic [3:0] pt);
    points = {12'h000, pt};
    req    = 4'b0001;
    step();
    req    = 4'b0000;
    step();
  endtask

  int n_av;

  initial begin
    tv[0]  = '{1'b0, 1'b0, 4'b0010, 16'h0030, 16'd0,  1'b0, 3'd0, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 4'b0010, 16'h0030, 16'd3,  1'b1, 3'd1, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 4'b0010, 16'h0030, 16'd3,  1'b0, 3'd1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 4'b0010, 16'h0030, 16'd3,  1'b0, 3'd1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 4'b0010, 16'h0030, 16'd3,  1'b0, 3'd1, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 4'b0000, 16'h0030, 16'd3,  1'b0, 3'd1, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 4'b0000, 16'h4321, 16'd0,  1'b0, 3'd0, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 4'b1111, 16'h4321, 16'd0,  1'b0, 3'd0, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 4'b1111, 16'h4321, 16'd1,  1'b1, 3'd0, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 4'b1111, 16'h4321, 16'd3,  1'b1, 3'd1, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b0, 4'b1111, 16'h4321, 16'd6,  1'b1, 3'd2, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b0, 4'b1111, 16'h4321, 16'd10, 1'b1, 3'd3, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b0, 4'b0000, 16'h4321, 16'd10, 1'b0, 3'd3, 1'b0, 1'b0};
    tv[13] = '{1'b0, 1'b0, 4'b1001, 16'h4321, 16'd10, 1'b0, 3'd3, 1'b1, 1'b0};
    tv[14] = '{1'b0, 1'b0, 4'b1000, 16'h4321, 16'd11, 1'b1, 3'd0, 1'b1, 1'b0};
    tv[15] = '{1'b0, 1'b0, 4'b1001, 16'h4321, 16'd15, 1'b1, 3'd3, 1'b1, 1'b0};
    tv[16] = '{1'b0, 1'b0, 4'b1000, 16'h4321, 16'd16, 1'b1, 3'd0, 1'b0, 1'b0};
    tv[17] = '{1'b0, 1'b0, 4'b0000, 16'h4321, 16'd16, 1'b0, 3'd0, 1'b0, 1'b0};

    resetN = 1'b0; clear = 1'b0; pause = 1'b0; req = '0; points = '0;
    step();
    step();
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_add_valid", 32'(add_valid), 32'd0);
    chk("rst_add_src", 32'(add_src), 32'd0);
    chk("rst_pending_any", 32'(pending_any), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    resetN = 1'b1;

    // single source, simultaneous burst, fairness
    for (int v = 0; v < 18; v++) begin
      clear  = tv[v].clr;
      pause  = tv[v].pau;
      req    = tv[v].rq;
      points = tv[v].pt;
      step();
      chk($sformatf("vec%0d_score", v), 32'(score), 32'(tv[v].e_score));
      chk($sformatf("vec%0d_add_valid", v), 32'(add_valid), 32'(tv[v].e_av));
      chk($sformatf("vec%0d_add_src", v), 32'(add_src), 32'(tv[v].e_src));
      chk($sformatf("vec%0d_pending_any", v), 32'(pending_any), 32'(tv[v].e_pend));
      chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'(tv[v].e_ovf));
    end

    // counter saturation under pause
    clear = 1'b1; req = '0; step(); clear = 1'b0;
    pause = 1'b1; points = 16'h0100;
    for (int e = 1; e <= 9; e++) begin
      req = 4'b0100;
      step();
      chk($sformatf("sat_edge%0d_overflow", e), 32'(overflow), (e >= 8) ? 32'd1 : 32'd0);
      chk($sformatf("sat_edge%0d_add_valid", e), 32'(add_valid), 32'd0);
      chk($sformatf("sat_edge%0d_pending", e), 32'(pending_any), 32'd1);
      req = 4'b0000;
      step();
    end
    chk("sat_paused_score", 32'(score), 32'd0);
    pause = 1'b0;
    n_av = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) chk("sat_resume_add_valid", 32'(add_valid), 32'd1);
      if (add_valid) n_av++;
    end
    chk("sat_grant_count", 32'(n_av), 32'd7);
    chk("sat_score", 32'(score), 32'd7);
    chk("sat_pending_any", 32'(pending_any), 32'd0);
    chk("sat_overflow_sticky", 32'(overflow), 32'd1);

    // clear beats a new edge and a pending award; held req must not re-award
    pause = 1'b1; req = 4'b0010;
    step();
    chk("clr_pre_pending", 32'(pending_any), 32'd1);
    clear = 1'b1; req = 4'b0011;
    step();
    clear = 1'b0; pause = 1'b0;
    chk("clr_score", 32'(score), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_pending_any", 32'(pending_any), 32'd0);
    chk("clr_add_valid", 32'(add_valid), 32'd0);
    chk("clr_add_src", 32'(add_src), 32'd0);
    n_av = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (add_valid) n_av++;
    end
    chk("clr_held_no_award", 32'(n_av), 32'd0);
    chk("clr_held_score", 32'(score), 32'd0);
    req = '0;
    step();

    // score saturation: 4368*15 + 14 = 0xFFFE, then +5 clamps
    for (int a = 0; a < 4368; a++) award(4'hF);
    award(4'hE);
    chk("ssat_preload", 32'(score), 32'h0000FFFE);
    award(4'h5);
    chk("ssat_add_valid", 32'(add_valid), 32'd1);
    chk("ssat_score", 32'(score), 32'h0000FFFF);
    award(4'h1);
    chk("ssat_hold", 32'(score), 32'h0000FFFF);

    // reset mid-operation with req held: one edge at the first clock after release
    req = 4'b0100; points = 16'h0700;
    resetN = 1'b0;
    #1;
    chk("mrst_score", 32'(score), 32'd0);
    chk("mrst_add_valid", 32'(add_valid), 32'd0);
    chk("mrst_pending_any", 32'(pending_any), 32'd0);
    chk("mrst_overflow", 32'(overflow), 32'd0);
    step();
    resetN = 1'b1;
    step();
    chk("mrst_edge_pending", 32'(pending_any), 32'd1);
    chk("mrst_edge_add_valid", 32'(add_valid), 32'd0);
    step();
    chk("mrst_grant_add_valid", 32'(add_valid), 32'd1);
    chk("mrst_grant_add_src", 32'(add_src), 32'd2);
    chk("mrst_grant_score", 32'(score), 32'd7);
    step();
    chk("mrst_single_award", 32'(add_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
